// File: rtl/watch_time_set.sv
// watch_time_set: button-driven time/date editor, writer side of watch_time
// Snapshots cur_* on the first mode press, steps year..sec with mode, edits the
// current field with up/down, then strobes set_load for one cycle. Inactivity
// on the 1 Hz enable aborts the edit without a load.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   clk1sec           1 Hz enable, one clk wide
//   btn_mode/up/down  raw button levels (synchronised here)
//   cur_*             running time from watch_time
//   set_*             edited time/date values
//   set_load          one-cycle strobe, set_* valid
//   set_active        high while editing a field
//   set_field         0 idle, 1 year .. 6 sec, 7 load
module watch_time_set #(
    parameter int YEAR_MIN    = 2000,
    parameter int YEAR_MAX    = 2099,
    parameter int TIMEOUT_SEC = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk1sec,
    input  logic        btn_mode,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic [13:0] cur_year,
    input  logic [7:0]  cur_month,
    input  logic [7:0]  cur_day,
    input  logic [7:0]  cur_hour,
    input  logic [7:0]  cur_min,
    input  logic [7:0]  cur_sec,
    output logic [13:0] set_year,
    output logic [7:0]  set_month,
    output logic [7:0]  set_day,
    output logic [7:0]  set_hour,
    output logic [7:0]  set_min,
    output logic [7:0]  set_sec,
    output logic        set_load,
    output logic        set_active,
    output logic [2:0]  set_field
);
    localparam int TW = $clog2(TIMEOUT_SEC + 1);

    typedef enum logic [2:0] {IDLE, S_YEAR, S_MONTH, S_DAY, S_HOUR, S_MIN, S_SEC, S_LOAD} state_t;

    state_t        state, state_nx;
    logic [2:0]    s1, s2, sd, p;
    logic          mode_p, up_p, dn_p, step;
    logic [TW-1:0] to_cnt, to_nx;
    logic [13:0]   y_nx;
    logic [7:0]    mo_nx, d_nx, h_nx, mi_nx, s_nx, dmax;

    function automatic logic [7:0] dim(input logic [7:0] m, input logic [13:0] y);
        logic leap;
        leap = (y[1:0] == 2'd0) && ((y % 14'd100 != 14'd0) || (y % 14'd400 == 14'd0));
        return (m == 8'd2) ? (leap ? 8'd29 : 8'd28) :
               (m == 8'd4 || m == 8'd6 || m == 8'd9 || m == 8'd11) ? 8'd30 : 8'd31;
    endfunction

    function automatic logic [7:0] wrap(input logic [7:0] v, input logic [7:0] lo,
                                        input logic [7:0] hi, input logic up);
        return up ? ((v >= hi) ? lo : v + 8'd1) : ((v <= lo) ? hi : v - 8'd1);
    endfunction

    // bit 2 mode, bit 1 up, bit 0 down; pulse on the synchronised rising edge
    assign p      = s2 & ~sd;
    assign mode_p = p[2];
    assign up_p   = p[1] & ~p[0];
    assign dn_p   = p[0] & ~p[1];
    assign step   = ~mode_p & (up_p | dn_p);

    assign set_load   = (state == S_LOAD);
    assign set_active = (state != IDLE) && (state != S_LOAD);
    assign set_field  = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
            sd <= '0;
        end else begin
            s1 <= {btn_mode, btn_up, btn_down};
            s2 <= s1;
            sd <= s2;
        end
    end

    always_comb begin
        state_nx = state;
        to_nx    = to_cnt;
        y_nx     = set_year;
        mo_nx    = set_month;
        d_nx     = set_day;
        h_nx     = set_hour;
        mi_nx    = set_min;
        s_nx     = set_sec;
        dmax     = 8'd31;
        case (state)
            IDLE: if (mode_p) begin
                state_nx = S_YEAR;
                to_nx    = '0;
                y_nx     = cur_year;
                mo_nx    = cur_month;
                d_nx     = cur_day;
                h_nx     = cur_hour;
                mi_nx    = cur_min;
                s_nx     = cur_sec;
            end
            S_LOAD: state_nx = IDLE;
            default: begin
                if (mode_p)
                    state_nx = state_t'(state + 3'd1);
                if (step) begin
                    case (state)
                        S_YEAR:  y_nx = up_p ? ((set_year >= 14'(YEAR_MAX)) ? 14'(YEAR_MIN) : set_year + 14'd1)
                                             : ((set_year <= 14'(YEAR_MIN)) ? 14'(YEAR_MAX) : set_year - 14'd1);
                        S_MONTH: mo_nx = wrap(set_month, 8'd1, 8'd12, up_p);
                        S_DAY:   d_nx  = wrap(set_day, 8'd1, dim(set_month, set_year), up_p);
                        S_HOUR:  h_nx  = wrap(set_hour, 8'd0, 8'd23, up_p);
                        S_MIN:   mi_nx = wrap(set_min, 8'd0, 8'd59, up_p);
                        default: s_nx  = wrap(set_sec, 8'd0, 8'd59, up_p);
                    endcase
                    // a year or month change must never leave the day past month end
                    dmax = dim(mo_nx, y_nx);
                    if ((state == S_YEAR || state == S_MONTH) && set_day > dmax)
                        d_nx = dmax;
                end
                // any button pulse restarts the inactivity window, even on a tick
                if (|p)
                    to_nx = '0;
                else if (clk1sec) begin
                    to_nx = (to_cnt == TW'(TIMEOUT_SEC - 1)) ? '0 : to_cnt + 1'b1;
                    if (to_cnt == TW'(TIMEOUT_SEC - 1))
                        state_nx = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            to_cnt    <= '0;
            set_year  <= 14'd2000;
            set_month <= 8'd1;
            set_day   <= 8'd1;
            set_hour  <= 8'd0;
            set_min   <= 8'd0;
            set_sec   <= 8'd0;
        end else begin
            state     <= state_nx;
            to_cnt    <= to_nx;
            set_year  <= y_nx;
            set_month <= mo_nx;
            set_day   <= d_nx;
            set_hour  <= h_nx;
            set_min   <= mi_nx;
            set_sec   <= s_nx;
        end
    end
endmodule

// File: tb/tb_watch_time_set.sv
// tb_watch_time_set: directed self-checking bench for watch_time_set
module tb_watch_time_set;
    logic        clk = 1'b0, rst = 1'b1, clk1sec = 1'b0;
    logic        btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic [13:0] cur_year = 14'd0;
    logic [7:0]  cur_month = 8'd0, cur_day = 8'd0, cur_hour = 8'd0, cur_min = 8'd0, cur_sec = 8'd0;
    logic [13:0] set_year;
    logic [7:0]  set_month, set_day, set_hour, set_min, set_sec;
    logic        set_load, set_active;
    logic [2:0]  set_field;
    int          checks = 0, errors = 0, loads = 0;

    watch_time_set dut (
        .clk(clk), .rst(rst), .clk1sec(clk1sec),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
        .cur_year(cur_year), .cur_month(cur_month), .cur_day(cur_day),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .set_year(set_year), .set_month(set_month), .set_day(set_day),
        .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
        .set_load(set_load), .set_active(set_active), .set_field(set_field)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (set_load === 1'b1) loads++;

    task automatic press(input logic m, input logic u, input logic d);
        @(negedge clk);
        btn_mode = m; btn_up = u; btn_down = d;
        repeat (4) @(negedge clk);
        btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic modes(input int n);
        repeat (n) press(1'b1, 1'b0, 1'b0);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk); clk1sec = 1'b1;
            @(negedge clk); clk1sec = 1'b0;
        end
    endtask

    task automatic set_cur(input int y, input int mo, input int d, input int h, input int mi, input int s);
        cur_year = 14'(y); cur_month = 8'(mo); cur_day = 8'(d);
        cur_hour = 8'(h); cur_min = 8'(mi); cur_sec = 8'(s);
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({set_year, set_month, set_day, set_hour, set_min, set_sec} !== {14'd2000, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0}) begin
            errors++; $display("FAIL reset_values got %0d/%0d/%0d %0d:%0d:%0d want 2000/1/1 0:0:0", set_year, set_month, set_day, set_hour, set_min, set_sec);
        end
        checks++;
        if ({set_load, set_active, set_field} !== 5'd0) begin
            errors++; $display("FAIL reset_flags got load=%b active=%b field=%0d want 0/0/0", set_load, set_active, set_field);
        end
        rst = 1'b1;
        set_cur(2024, 2, 10, 12, 34, 56);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        checks++;
        if ({set_field, set_year, set_month, set_day} !== {3'd0, 14'd2000, 8'd1, 8'd1}) begin
            errors++; $display("FAIL idle_ignore got field=%0d %0d/%0d/%0d want 0 2000/1/1", set_field, set_year, set_month, set_day);
        end
    endtask

    task automatic test_load_flow;
        set_cur(2024, 2, 10, 12, 34, 56);
        loads = 0;
        modes(1);
        checks++;
        if (set_field !== 3'd1) begin errors++; $display("FAIL enter_field got %0d want 1", set_field); end
        checks++;
        if (set_active !== 1'b1) begin errors++; $display("FAIL enter_active got %b want 1", set_active); end
        checks++;
        if ({set_year, set_month, set_day, set_hour, set_min, set_sec} !== {14'd2024, 8'd2, 8'd10, 8'd12, 8'd34, 8'd56}) begin
            errors++; $display("FAIL snapshot got %0d/%0d/%0d %0d:%0d:%0d want 2024/2/10 12:34:56", set_year, set_month, set_day, set_hour, set_min, set_sec);
        end
        set_cur(2031, 7, 7, 7, 7, 7);
        modes(5);
        checks++;
        if (set_field !== 3'd6 || loads != 0) begin errors++; $display("FAIL sec_field got field=%0d loads=%0d want 6/0", set_field, loads); end
        modes(1);
        checks++;
        if (loads != 1) begin errors++; $display("FAIL load_count got %0d want 1", loads); end
        checks++;
        if ({set_field, set_active} !== 4'd0) begin errors++; $display("FAIL after_load got field=%0d active=%b want 0/0", set_field, set_active); end
        checks++;
        if ({set_year, set_month, set_day, set_hour, set_min, set_sec} !== {14'd2024, 8'd2, 8'd10, 8'd12, 8'd34, 8'd56}) begin
            errors++; $display("FAIL load_values got %0d/%0d/%0d %0d:%0d:%0d want 2024/2/10 12:34:56", set_year, set_month, set_day, set_hour, set_min, set_sec);
        end
    endtask

    task automatic test_day_clamp;
        set_cur(2023, 1, 31, 0, 0, 0);
        modes(2);
        press(1'b0, 1'b1, 1'b0);
        checks++;
        if ({set_month, set_day} !== {8'd2, 8'd28}) begin errors++; $display("FAIL clamp_2023 got %0d/%0d want 2/28", set_month, set_day); end
        modes(5);
        set_cur(2024, 1, 31, 0, 0, 0);
        modes(2);
        press(1'b0, 1'b1, 1'b0);
        checks++;
        if ({set_month, set_day} !== {8'd2, 8'd29}) begin errors++; $display("FAIL clamp_2024_up got %0d/%0d want 2/29", set_month, set_day); end
        modes(1);
        press(1'b0, 1'b1, 1'b0);
        checks++;
        if (set_day !== 8'd1) begin errors++; $display("FAIL day_wrap_up got %0d want 1", set_day); end
        press(1'b0, 1'b0, 1'b1);
        checks++;
        if (set_day !== 8'd29) begin errors++; $display("FAIL day_wrap_down got %0d want 29", set_day); end
        modes(4);
        set_cur(2024, 3, 31, 0, 0, 0);
        modes(2);
        press(1'b0, 1'b0, 1'b1);
        checks++;
        if ({set_month, set_day} !== {8'd2, 8'd29}) begin errors++; $display("FAIL clamp_2024_down got %0d/%0d want 2/29", set_month, set_day); end
        modes(5);
        set_cur(2024, 2, 29, 0, 0, 0);
        modes(1);
        press(1'b0, 1'b1, 1'b0);
        checks++;
        if ({set_year, set_day} !== {14'd2025, 8'd28}) begin errors++; $display("FAIL clamp_year got %0d day %0d want 2025 day 28", set_year, set_day); end
        modes(6);
    endtask

    task automatic test_wrap;
        set_cur(2099, 1, 15, 0, 0, 59);
        loads = 0;
        modes(1);
        press(1'b0, 1'b1, 1'b0);
        checks++;
        if (set_year !== 14'd2000) begin errors++; $display("FAIL year_wrap_up got %0d want 2000", set_year); end
        press(1'b0, 1'b0, 1'b1);
        checks++;
        if (set_year !== 14'd2099) begin errors++; $display("FAIL year_wrap_down got %0d want 2099", set_year); end
        modes(1);
        press(1'b0, 1'b0, 1'b1);
        checks++;
        if (set_month !== 8'd12) begin errors++; $display("FAIL month_wrap got %0d want 12", set_month); end
        modes(2);
        press(1'b0, 1'b0, 1'b1);
        checks++;
        if (set_hour !== 8'd23) begin errors++; $display("FAIL hour_wrap got %0d want 23", set_hour); end
        modes(1);
        press(1'b0, 1'b0, 1'b1);
        checks++;
        if (set_min !== 8'd59) begin errors++; $display("FAIL min_wrap got %0d want 59", set_min); end
        modes(1);
        press(1'b0, 1'b1, 1'b0);
        checks++;
        if (set_sec !== 8'd0) begin errors++; $display("FAIL sec_wrap got %0d want 0", set_sec); end
        modes(1);
        checks++;
        if (loads != 1 || {set_year, set_month, set_day, set_hour, set_min, set_sec} !== {14'd2099, 8'd12, 8'd15, 8'd23, 8'd59, 8'd0}) begin
            errors++; $display("FAIL wrap_load got loads=%0d %0d/%0d/%0d %0d:%0d:%0d want 1 2099/12/15 23:59:0", loads, set_year, set_month, set_day, set_hour, set_min, set_sec);
        end
    endtask

    task automatic test_both_and_hold;
        set_cur(2024, 2, 10, 12, 34, 56);
        modes(1);
        press(1'b0, 1'b1, 1'b1);
        checks++;
        if (set_year !== 14'd2024) begin errors++; $display("FAIL up_down_same got %0d want 2024", set_year); end
        @(negedge clk); btn_up = 1'b1;
        repeat (100) @(negedge clk);
        btn_up = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (set_year !== 14'd2025) begin errors++; $display("FAIL held_up got %0d want 2025", set_year); end
        loads = 0;
        tick(30);
        checks++;
        if (set_field !== 3'd0 || loads != 0) begin errors++; $display("FAIL year_timeout got field=%0d loads=%0d want 0/0", set_field, loads); end
    endtask

    task automatic test_timeout;
        set_cur(2024, 2, 10, 12, 34, 56);
        loads = 0;
        modes(5);
        checks++;
        if (set_field !== 3'd5) begin errors++; $display("FAIL min_field got %0d want 5", set_field); end
        tick(29);
        press(1'b0, 1'b1, 1'b0);
        tick(29);
        checks++;
        if (set_field !== 3'd5 || set_active !== 1'b1) begin errors++; $display("FAIL restart_no_abort got field=%0d active=%b want 5/1", set_field, set_active); end
        tick(1);
        checks++;
        if (set_field !== 3'd0 || set_active !== 1'b0) begin errors++; $display("FAIL abort got field=%0d active=%b want 0/0", set_field, set_active); end
        checks++;
        if (loads != 0) begin errors++; $display("FAIL abort_no_load got %0d want 0", loads); end
        checks++;
        if ({set_year, set_month, set_day, set_hour, set_min, set_sec} !== {14'd2024, 8'd2, 8'd10, 8'd12, 8'd35, 8'd56}) begin
            errors++; $display("FAIL abort_keep got %0d/%0d/%0d %0d:%0d:%0d want 2024/2/10 12:35:56", set_year, set_month, set_day, set_hour, set_min, set_sec);
        end
    endtask

    task automatic test_async_reset;
        set_cur(2024, 2, 10, 12, 34, 56);
        loads = 0;
        modes(1);
        press(1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({set_year, set_month, set_day, set_hour, set_min, set_sec} !== {14'd2000, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0}) begin
            errors++; $display("FAIL async_values got %0d/%0d/%0d %0d:%0d:%0d want 2000/1/1 0:0:0", set_year, set_month, set_day, set_hour, set_min, set_sec);
        end
        checks++;
        if ({set_load, set_active, set_field} !== 5'd0) begin errors++; $display("FAIL async_flags got load=%b active=%b field=%0d want 0/0/0", set_load, set_active, set_field); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (loads != 0 || set_field !== 3'd0) begin errors++; $display("FAIL async_after got loads=%0d field=%0d want 0/0", loads, set_field); end
    endtask

    initial begin
        test_reset;
        test_load_flow;
        test_day_clamp;
        test_wrap;
        test_both_and_hold;
        test_timeout;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
